// File: rtl/stq_pkg.sv
// Store-queue shared types: entry layout, pointer types and sizing.
// Imported by the queue, its interface and the age selector.
package stq_pkg;

   localparam int DEPTH_LOG  = 3;
   localparam int DEPTH      = 2 ** DEPTH_LOG;
   localparam int WIDTH_MEM  = 4;
   localparam int WIDTH_DATA = 32;
   localparam int WIDTH_BRM  = 4;

   // Pointers carry one extra wrap bit to tell full from empty.
   typedef logic [DEPTH_LOG:0]   ptr_t;
   typedef logic [DEPTH_LOG-1:0] idx_t;

   typedef struct packed {
      logic                  valid;
      logic                  committed;
      logic [WIDTH_BRM-1:0]  brmask;
      logic [WIDTH_MEM-1:0]  addr;
      logic [WIDTH_DATA-1:0] data;
   } stq_entry_t;

   function automatic idx_t ptr_idx(ptr_t p);
      return p[DEPTH_LOG-1:0];
   endfunction

endpackage

// File: rtl/stq_fwd_if.sv
// Store-queue bus: AGU enqueue, ROB commit, branch resolution,
// load lookup and the dcache write port.
interface stq_fwd_if;
   import stq_pkg::*;

   logic                  i_st_val;
   logic [WIDTH_MEM-1:0]  i_st_addr;
   logic [WIDTH_DATA-1:0] i_st_data;
   logic [WIDTH_BRM-1:0]  i_st_brmask;
   logic                  o_st_rdy;
   logic [DEPTH_LOG-1:0]  o_st_idx;
   logic                  i_commit;
   logic [WIDTH_BRM-1:0]  i_brkill;
   logic [WIDTH_BRM-1:0]  i_brok;
   logic                  i_ld_val;
   logic [WIDTH_MEM-1:0]  i_ld_addr;
   logic                  o_ld_hit;
   logic [WIDTH_DATA-1:0] o_ld_data;
   logic                  o_dc_we;
   logic [WIDTH_MEM-1:0]  o_dc_addr;
   logic [WIDTH_DATA-1:0] o_dc_data;
   logic                  i_dc_nack;
   logic [DEPTH_LOG:0]    o_count;

   modport slave (
      input  i_st_val, i_st_addr, i_st_data, i_st_brmask,
      input  i_commit, i_brkill, i_brok,
      input  i_ld_val, i_ld_addr, i_dc_nack,
      output o_st_rdy, o_st_idx, o_ld_hit, o_ld_data,
      output o_dc_we, o_dc_addr, o_dc_data, o_count
   );

   modport master (
      output i_st_val, i_st_addr, i_st_data, i_st_brmask,
      output i_commit, i_brkill, i_brok,
      output i_ld_val, i_ld_addr, i_dc_nack,
      input  o_st_rdy, o_st_idx, o_ld_hit, o_ld_data,
      input  o_dc_we, o_dc_addr, o_dc_data, o_count
   );

endinterface

// File: rtl/stq_age_sel.sv
// Youngest-match picker for a circular queue: rotates the match
// vector so the head is bit 0, then takes the highest set bit.
module stq_age_sel
   import stq_pkg::*;
(
   input  logic [DEPTH-1:0] i_match,
   input  idx_t             i_head,
   output logic             o_hit,
   output idx_t             o_idx
);

   logic [DEPTH-1:0] rot;

   // Reorder matches by age, oldest (head) first.
   always_comb begin
      rot = '0;
      for (int i = 0; i < DEPTH; i++) begin
         rot[i] = i_match[i_head + idx_t'(i)];
      end
   end

   // Last hit in ascending age order is the youngest.
   always_comb begin
      o_hit = |rot;
      o_idx = i_head;
      for (int i = 0; i < DEPTH; i++) begin
         if (rot[i]) begin
            o_idx = i_head + idx_t'(i);
         end
      end
   end

endmodule

// File: rtl/stq_fwd.sv
// Speculative store queue: branch-mask squash, in-order commit,
// nack-tolerant dcache drain and youngest-match load forwarding.
module stq_fwd
   import stq_pkg::*;
(
   input  logic      i_clk,
   input  logic      i_rst_n,
   stq_fwd_if.slave  bus
);

   localparam ptr_t PTR_ONE = ptr_t'(1);
   localparam ptr_t PTR_FULL = ptr_t'(DEPTH);

   stq_entry_t ent_q [DEPTH];
   stq_entry_t ent_d [DEPTH];

   ptr_t head_q, head_d;
   ptr_t cmt_q, cmt_d;
   ptr_t tail_q, tail_d;

   ptr_t count;
   ptr_t kill_ptr;
   idx_t head_idx, cmt_idx, tail_idx;
   idx_t sel_idx;

   logic [DEPTH-1:0] kill_vec;
   logic [DEPTH-1:0] match_vec;
   logic any_kill, suppress, st_rdy;
   logic enq, cmt_fire, dc_we, drain;
   logic sel_hit;

   assign head_idx = ptr_idx(head_q);
   assign cmt_idx  = ptr_idx(cmt_q);
   assign tail_idx = ptr_idx(tail_q);
   assign count    = tail_q - head_q;
   assign st_rdy   = (count != PTR_FULL);
   assign dc_we    = ent_q[head_idx].valid
                   & ent_q[head_idx].committed;

   assign bus.o_count   = count;
   assign bus.o_st_rdy  = st_rdy;
   assign bus.o_st_idx  = tail_idx;
   assign bus.o_dc_we   = dc_we;
   assign bus.o_dc_addr = ent_q[head_idx].addr;
   assign bus.o_dc_data = ent_q[head_idx].data;

   // Flag wrong-path entries and find the oldest one for tail rollback.
   always_comb begin
      kill_vec = '0;
      kill_ptr = tail_q;
      for (int i = 0; i < DEPTH; i++) begin
         kill_vec[i] = ent_q[i].valid & ~ent_q[i].committed
                     & (|(ent_q[i].brmask & bus.i_brkill));
      end
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (kill_vec[head_idx + idx_t'(i)]) begin
            kill_ptr = head_q + ptr_t'(i);
         end
      end
   end

   // Per-cycle events; a kill blocks enqueue and beats a commit.
   always_comb begin
      any_kill = |kill_vec;
      suppress = (|(bus.i_st_brmask & bus.i_brkill)) | any_kill;
      enq      = bus.i_st_val & st_rdy & ~suppress;
      cmt_fire = bus.i_commit & (cmt_q != tail_q)
               & ~kill_vec[cmt_idx];
      drain    = dc_we & ~bus.i_dc_nack;
   end

   // Next-state for entries and pointers.
   always_comb begin
      ent_d  = ent_q;
      head_d = head_q;
      cmt_d  = cmt_q;
      tail_d = tail_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_q[i].valid & ~ent_q[i].committed) begin
            ent_d[i].brmask = ent_q[i].brmask & ~bus.i_brok;
            if (kill_vec[i]) begin
               ent_d[i].valid = 1'b0;
            end
         end
      end
      if (any_kill) begin
         tail_d = kill_ptr;
      end
      if (cmt_fire) begin
         ent_d[cmt_idx].committed = 1'b1;
         cmt_d = cmt_q + PTR_ONE;
      end
      if (drain) begin
         ent_d[head_idx] = '0;
         head_d = head_q + PTR_ONE;
      end
      if (enq) begin
         ent_d[tail_idx].valid     = 1'b1;
         ent_d[tail_idx].committed = 1'b0;
         ent_d[tail_idx].brmask    = bus.i_st_brmask & ~bus.i_brok;
         ent_d[tail_idx].addr      = bus.i_st_addr;
         ent_d[tail_idx].data      = bus.i_st_data;
         tail_d = tail_q + PTR_ONE;
      end
   end

   // State registers; reset drops every entry, committed or not.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
         end
         head_q <= '0;
         cmt_q  <= '0;
         tail_q <= '0;
      end else begin
         ent_q  <= ent_d;
         head_q <= head_d;
         cmt_q  <= cmt_d;
         tail_q <= tail_d;
      end
   end

   // Address match over every live entry, killed or draining included.
   always_comb begin
      match_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         match_vec[i] = ent_q[i].valid
                      & (ent_q[i].addr == bus.i_ld_addr);
      end
   end

   stq_age_sel u_age_sel (
      .i_match (match_vec),
      .i_head  (head_idx),
      .o_hit   (sel_hit),
      .o_idx   (sel_idx)
   );

   assign bus.o_ld_hit  = bus.i_ld_val & sel_hit;
   assign bus.o_ld_data = (bus.i_ld_val & sel_hit)
                        ? ent_q[sel_idx].data : '0;

endmodule

// File: tb/tb_stq_fwd.sv
// Store-queue bench: directed stimulus pushes expectations, a
// negedge monitor pops and compares them and scores dcache writes.
module tb_stq_fwd;

   typedef enum int {
      K_RDY, K_CNT, K_IDX, K_HIT, K_LDATA,
      K_WE, K_DADDR, K_DDATA
   } kind_e;

   typedef struct {
      kind_e       k;
      logic [31:0] v;
   } exp_t;

   typedef struct {
      logic [3:0]  a;
      logic [31:0] d;
   } dc_t;

   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_tot;
   logic fin_req;

   exp_t exp_q[$];
   dc_t  dc_q[$];

   logic [3:0] wa [5] = '{4'd9, 4'd10, 4'd9, 4'd10, 4'd11};
   int         wi [5] = '{6, 7, 0, 1, 2};

   stq_fwd_if bus ();

   stq_fwd u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] act(kind_e k);
      case (k)
         K_RDY:   return 32'(bus.o_st_rdy);
         K_CNT:   return 32'(bus.o_count);
         K_IDX:   return 32'(bus.o_st_idx);
         K_HIT:   return 32'(bus.o_ld_hit);
         K_LDATA: return bus.o_ld_data;
         K_WE:    return 32'(bus.o_dc_we);
         K_DADDR: return 32'(bus.o_dc_addr);
         K_DDATA: return bus.o_dc_data;
         default: return '0;
      endcase
   endfunction

   task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
      n_tot++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h @%0t",
                    nm, a, e, $time);
   endtask

   // Monitor: compare queued expectations and score dcache writes.
   always @(negedge clk) begin
      exp_t e;
      dc_t  d;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk(e.k.name(), act(e.k), e.v);
      end
      if (bus.o_dc_we && !bus.i_dc_nack) begin
         if (dc_q.size() == 0) begin
            chk("dc_unexpected_write", 32'(bus.o_dc_we), 32'd0);
         end else begin
            d = dc_q.pop_front();
            chk("dc_wr_addr", 32'(bus.o_dc_addr), 32'(d.a));
            chk("dc_wr_data", bus.o_dc_data, d.d);
         end
      end
      if (fin_req) begin
         chk("dc_writes_left", dc_q.size(), 32'd0);
      end
   end

   task automatic ex(kind_e k, logic [31:0] v);
      exp_t e;
      e.k = k;
      e.v = v;
      exp_q.push_back(e);
   endtask

   task automatic dcx(logic [3:0] a, logic [31:0] d);
      dc_t x;
      x.a = a;
      x.d = d;
      dc_q.push_back(x);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.i_st_val    = 1'b0;
      bus.i_st_addr   = '0;
      bus.i_st_data   = '0;
      bus.i_st_brmask = '0;
      bus.i_commit    = 1'b0;
      bus.i_brkill    = '0;
      bus.i_brok      = '0;
      bus.i_ld_val    = 1'b0;
      bus.i_ld_addr   = '0;
      bus.i_dc_nack   = 1'b0;
   endtask

   task automatic st(logic [3:0] a, logic [31:0] d, logic [3:0] m);
      idle();
      bus.i_st_val    = 1'b1;
      bus.i_st_addr   = a;
      bus.i_st_data   = d;
      bus.i_st_brmask = m;
   endtask

   task automatic ld(logic [3:0] a);
      bus.i_ld_val  = 1'b1;
      bus.i_ld_addr = a;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
   endtask

   initial begin
      n_pass  = 0;
      n_tot   = 0;
      fin_req = 1'b0;
      rst_n   = 1'b0;
      idle();
      cyc();

      // reset state
      ld(4'd0);
      ex(K_RDY, 1); ex(K_CNT, 0); ex(K_IDX, 0);
      ex(K_WE, 0); ex(K_HIT, 0); ex(K_LDATA, 0);
      cyc();
      rst_n = 1'b1;

      // fill to full, 9th refused
      for (int i = 0; i < 8; i++) begin
         st(4'(i), 32'h100 + 32'(i), 4'd0);
         ex(K_IDX, 32'(i)); ex(K_CNT, 32'(i)); ex(K_RDY, 1);
         cyc();
      end
      st(4'd8, 32'h108, 4'd0);
      ld(4'd5);
      ex(K_RDY, 0); ex(K_CNT, 8); ex(K_IDX, 0);
      ex(K_HIT, 1); ex(K_LDATA, 32'h105);
      cyc();
      idle();
      ex(K_CNT, 8); ex(K_IDX, 0); ex(K_RDY, 0);
      cyc();
      do_reset();

      // youngest same-address forwarding
      st(4'd3, 32'hAA, 4'd0); cyc();
      st(4'd3, 32'hBB, 4'd0); cyc();
      idle(); ld(4'd3);
      ex(K_HIT, 1); ex(K_LDATA, 32'hBB); ex(K_CNT, 2);
      cyc();
      idle(); ld(4'd5);
      ex(K_HIT, 0); ex(K_LDATA, 0);
      cyc();
      idle(); bus.i_ld_addr = 4'd3;
      ex(K_HIT, 0); ex(K_LDATA, 0);
      cyc();
      do_reset();

      // branch kill with suppressed enqueue, then brok clearing
      st(4'd1, 32'h1, 4'd0); cyc();
      st(4'd2, 32'h2, 4'd2); cyc();
      st(4'd3, 32'h3, 4'd2); cyc();
      st(4'd9, 32'h99, 4'd0);
      bus.i_brkill = 4'd2; ld(4'd3);
      ex(K_HIT, 1); ex(K_LDATA, 32'h3); ex(K_CNT, 3);
      cyc();
      idle(); ld(4'd2);
      ex(K_CNT, 1); ex(K_IDX, 1); ex(K_HIT, 0); ex(K_LDATA, 0);
      cyc();
      st(4'd4, 32'h44, 4'd4); cyc();
      st(4'd5, 32'h55, 4'd4); bus.i_brok = 4'd4; cyc();
      idle(); bus.i_brkill = 4'd4;
      ex(K_CNT, 3);
      cyc();
      idle(); ld(4'd5);
      ex(K_CNT, 3); ex(K_IDX, 3); ex(K_HIT, 1); ex(K_LDATA, 32'h55);
      cyc();
      do_reset();

      // commit under nack, then in-order drain
      dcx(4'd6, 32'h66);
      dcx(4'd7, 32'h77);
      st(4'd6, 32'h66, 4'd0); cyc();
      st(4'd7, 32'h77, 4'd0); cyc();
      idle(); bus.i_commit = 1'b1; bus.i_dc_nack = 1'b1;
      ex(K_WE, 0);
      cyc();
      idle(); bus.i_commit = 1'b1; bus.i_dc_nack = 1'b1;
      ex(K_WE, 1); ex(K_DADDR, 6); ex(K_DDATA, 32'h66);
      cyc();
      for (int i = 0; i < 2; i++) begin
         idle(); bus.i_dc_nack = 1'b1;
         ex(K_WE, 1); ex(K_DADDR, 6); ex(K_DDATA, 32'h66);
         cyc();
      end
      idle();
      ex(K_WE, 1); ex(K_DADDR, 6); ex(K_DDATA, 32'h66);
      cyc();
      idle();
      ex(K_WE, 1); ex(K_DADDR, 7); ex(K_DDATA, 32'h77);
      cyc();
      idle(); bus.i_commit = 1'b1;
      ex(K_WE, 0); ex(K_CNT, 0); ex(K_IDX, 2);
      cyc();
      st(4'd1, 32'h11, 4'd0);
      ex(K_IDX, 2);
      cyc();
      idle(); bus.i_commit = 1'b1;
      ex(K_WE, 0); ex(K_CNT, 1); ex(K_IDX, 3);
      cyc();
      idle(); bus.i_dc_nack = 1'b1;
      ex(K_WE, 1); ex(K_DADDR, 1); ex(K_DDATA, 32'h11);
      cyc();
      do_reset();

      // drain six, refill across the wrap point
      for (int i = 0; i < 6; i++) begin
         st(4'(i), 32'h200 + 32'(i), 4'd0);
         dcx(4'(i), 32'h200 + 32'(i));
         cyc();
      end
      for (int i = 0; i < 6; i++) begin
         idle(); bus.i_commit = 1'b1;
         cyc();
      end
      idle(); cyc();
      idle();
      ex(K_CNT, 0); ex(K_IDX, 6); ex(K_WE, 0);
      cyc();
      for (int k = 0; k < 5; k++) begin
         st(wa[k], 32'hA0 + 32'(k), 4'd0);
         ex(K_IDX, 32'(wi[k])); ex(K_CNT, 32'(k));
         cyc();
      end
      idle(); ld(4'd9);
      ex(K_HIT, 1); ex(K_LDATA, 32'hA2); ex(K_CNT, 5); ex(K_IDX, 3);
      cyc();
      idle(); ld(4'd10);
      ex(K_LDATA, 32'hA3);
      cyc();
      idle(); ld(4'd11);
      ex(K_LDATA, 32'hA4);
      cyc();

      // asynchronous reset in the middle of a held drain
      idle(); bus.i_commit = 1'b1; bus.i_dc_nack = 1'b1;
      cyc();
      idle(); bus.i_commit = 1'b1; bus.i_dc_nack = 1'b1;
      ex(K_WE, 1); ex(K_DADDR, 9); ex(K_DDATA, 32'hA0);
      cyc();
      idle(); bus.i_dc_nack = 1'b1;
      #1;
      rst_n = 1'b0;
      ld(4'd9);
      ex(K_WE, 0); ex(K_CNT, 0); ex(K_RDY, 1);
      ex(K_IDX, 0); ex(K_HIT, 0);
      cyc();
      rst_n = 1'b1;
      st(4'd2, 32'h33, 4'd0);
      ex(K_IDX, 0); ex(K_CNT, 0);
      cyc();
      idle(); ld(4'd2);
      ex(K_CNT, 1); ex(K_IDX, 1); ex(K_HIT, 1); ex(K_LDATA, 32'h33);
      cyc();

      idle();
      fin_req = 1'b1;
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/stq_fwd.md
Name: stq_fwd

Overview:
Parametrised store queue that succeeds the SAQ/LAQ pair inside the AGU. It holds speculative stores in a circular buffer and forwards store data to younger loads. It squashes wrong-path stores using branch masks, and drains committed stores in order to the data cache, retrying when the cache sends a nack. It sits between the AGU address path and the dcache port.

Parameters:
DEPTH_LOG, 3, log2 of entry count (DEPTH = 2**DEPTH_LOG)
WIDTH_MEM, 4, dcache word-address width
WIDTH_DATA, 32, store data width
WIDTH_BRM, 4, branch-mask width

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  reset, asynchronous, active-low
i_st_val  in  1  enqueue request
i_st_addr  in  WIDTH_MEM  store address
i_st_data  in  WIDTH_DATA  store data
i_st_brmask  in  WIDTH_BRM  branches this store depends on
o_st_rdy  out  1  queue not full
o_st_idx  out  DEPTH_LOG  slot the next enqueue will use (current tail)
i_commit  in  1  commit the oldest uncommitted store
i_brkill  in  WIDTH_BRM  mispredicted-branch bits (one-hot or zero)
i_brok  in  WIDTH_BRM  correctly resolved branch bits, to be cleared from masks
i_ld_val  in  1  load lookup valid
i_ld_addr  in  WIDTH_MEM  load address
o_ld_hit  out  1  forward hit
o_ld_data  out  WIDTH_DATA  forwarded data
o_dc_we  out  1  dcache write request
o_dc_addr  out  WIDTH_MEM  dcache write address
o_dc_data  out  WIDTH_DATA  dcache write data
i_dc_nack  in  1  dcache rejects this cycle's request
o_count  out  DEPTH_LOG+1  occupied entries

Behaviour:
- Storage and pointers
  - Per-entry state: valid, committed, brmask, addr, data.
  - Pointers head, cmt and tail are each DEPTH_LOG+1 bits, using the wrap bit for full/empty.
  - Ordering invariant: head <= cmt <= tail, in circular order.
- Reset (asynchronous, i_rst_n=0)
  - All pointers are 0 and all valid/committed bits are 0.
  - Outputs during reset: o_st_rdy=1, o_dc_we=0, o_ld_hit=0, o_count=0, o_st_idx=0.
  - Reset mid-drain discards every entry, including committed ones.
- Enqueue
  - An enqueue fires on a clock edge when i_st_val & o_st_rdy & ~suppress.
  - The entry is written at tail with brmask = i_st_brmask & ~i_brok, then tail increments.
  - suppress = (i_st_brmask & i_brkill) != 0, OR any queued entry is killed this cycle.
- Full/empty and count
  - o_st_rdy = (o_count != DEPTH).
  - No same-cycle bypass: when full, an enqueue is refused even if a drain occurs that cycle.
- Branch resolution (uncommitted entries only)
  - Every uncommitted valid entry clears the i_brok bits from its brmask.
  - Any uncommitted entry with brmask & i_brkill != 0 is invalidated.
  - Killed entries always form a contiguous youngest suffix; tail rolls back to the oldest killed index.
  - Committed entries ignore i_brkill.
- Commit
  - i_commit with cmt != tail marks entry cmt as committed and increments cmt.
  - i_commit with cmt == tail is ignored.
  - A commit on an entry killed in the same cycle is ignored; kill wins.
- Drain
  - o_dc_we = valid[head] & committed[head], combinational.
  - o_dc_addr and o_dc_data come from the head entry.
  - On a clock edge with o_dc_we & ~i_dc_nack: the head entry is cleared and head increments.
  - On a nack the same request is held and retried the next cycle.
  - Enqueue, commit, drain and kill may all occur in one cycle; o_count reflects the net change.
- Load forwarding (combinational, zero latency)
  - o_ld_hit = i_ld_val & (some valid entry has addr == i_ld_addr).
  - o_ld_data comes from the youngest matching entry (closest to tail).
  - Entries being killed or drained in the current cycle still participate.
  - When there is no hit, o_ld_data = 0.
- Wrap-around
  - Pointers wrap modulo 2*DEPTH.
  - The youngest-match search is relative to head, so the search wraps with the pointers.

Decomposition:
- Package stq_pkg contains:
  - typedef stq_entry_t {valid, committed, brmask, addr, data}
  - localparam DEPTH
  - function ptr_idx() that strips the wrap bit
- Sub-module stq_age_sel: takes the DEPTH-bit match vector and the head index, rotates the vector, priority-selects the youngest match, and returns the hit flag and index. It is reused later for load-queue ordering checks.

Test Plan:
- Reset, then enqueue 8 stores with addr=i, data=0x100+i -> o_st_rdy=0 and o_count=8; a 9th enqueue is refused and tail is unchanged.
- Stores A(addr3,0xAA) and B(addr3,0xBB), then a load to addr3 -> o_ld_hit=1 and o_ld_data=0xBB; a load to addr5 -> o_ld_hit=0 and o_ld_data=0.
- Three stores with brmask 0,2,2, then i_brkill=2 -> count=1, tail=1; an enqueue in the same cycle with brmask 0 is suppressed.
- Commit 2 stores with i_dc_nack=1 for 3 cycles -> o_dc_we stays 1 with the same addr/data; after the nack drops, 2 writes occur in order and head=2.
- Fill, drain and refill past index 7 so the pointers wrap -> forwarding still picks the youngest match across the wrap point; o_count stays correct.
- Assert i_rst_n=0 mid-drain, between clock edges -> o_dc_we falls immediately and o_count=0; after release the first enqueue goes to slot 0.
